// File: rtl/cpu_pkg.sv
// Shared encodings for the MIPS pipeline: ALU ops, mult/div ops, result and forward selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_SLLV = 4'd11,
    ALU_SRLV = 4'd12,
    ALU_SRAV = 4'd13
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_HI  = 2'd1,
    RES_LO  = 2'd2,
    RES_PC8 = 2'd3
  } res_sel_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // True for the ops that occupy the iterative unit (mult/multu/div/divu).
  function automatic logic md_is_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit: result computed at start, committed to HI/LO after a fixed busy count.
// Latency: MULT_CYCLES / DIV_CYCLES edges from start to HI/LO commit; mthi/mtlo write in one edge.
// Backpressure: none internally; the caller must only start/move-to while busy_o is low.
module md_unit
  import cpu_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            wr_hi_i,
  input  logic            wr_lo_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [2*XLEN-1:0] prod_s, prod_u;
  logic [XLEN-1:0]   res_hi, res_lo;

  // Result of the op being started, from the operands present at the start edge.
  always_comb begin
    prod_s = $signed({{XLEN{a_i[XLEN-1]}}, a_i}) * $signed({{XLEN{b_i[XLEN-1]}}, b_i});
    prod_u = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};
    res_hi = '0;
    res_lo = '0;
    case (op_i)
      MD_MULT: begin
        res_hi = prod_s[2*XLEN-1:XLEN];
        res_lo = prod_s[XLEN-1:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[2*XLEN-1:XLEN];
        res_lo = prod_u[XLEN-1:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b_i == '0) begin
          // Divide by zero: remainder slot keeps the dividend, quotient saturates to all ones.
          res_hi = a_i;
          res_lo = '1;
        end else if (op_i == MD_DIV) begin
          res_lo = $signed(a_i) / $signed(b_i);
          res_hi = $signed(a_i) % $signed(b_i);
        end else begin
          res_lo = a_i / b_i;
          res_hi = a_i % b_i;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

  // Counter, pending-result and HI/LO next state.
  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (start_i) begin
      cnt_d     = ((op_i == MD_MULT) || (op_i == MD_MULTU)) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      pend_hi_d = res_hi;
      pend_lo_d = res_lo;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end
    if (wr_hi_i) hi_d = wdata_i;
    if (wr_lo_i) lo_d = wdata_i;
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: forwarding muxes, combinational ALU, mult/div unit and the EX/MEM register.
// Latency: one edge into EX/MEM; HI/LO results MULT_CYCLES / DIV_CYCLES edges after start.
// Backpressure: md_stall_req holds IF/ID/EX while a HI/LO user meets a busy unit; bubbles fill EX/MEM.
module ex_stage_md
  import cpu_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter int              MULT_CYCLES = 5,
  parameter int              DIV_CYCLES  = 10,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [3:0]      in_alu_op,
  input  logic            in_src1_imm,
  input  logic [2:0]      in_md_op,
  input  logic [1:0]      in_res_sel,
  input  logic [XLEN-1:0] in_rs_data,
  input  logic [XLEN-1:0] in_rt_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_shamt,
  input  logic [4:0]      in_waddr,
  input  logic [2:0]      in_tnew,
  input  logic [1:0]      fwd_rs_sel,
  input  logic [1:0]      fwd_rt_sel,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic            md_busy,
  output logic            md_stall_req,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_dm_wdata,
  output logic [4:0]      out_waddr,
  output logic [2:0]      out_tnew
);

  logic [XLEN-1:0] rs_f, rt_f, alu_a, alu_b, alu_res, hi, lo, result;
  logic            md_uses, fire, md_start, wr_hi, wr_lo, bubble;

  // Operand forwarding; the unused select code falls back to the register file.
  always_comb begin
    case (fwd_rs_sel)
      FWD_MEM: rs_f = fwd_mem_data;
      FWD_WB:  rs_f = fwd_wb_data;
      default: rs_f = in_rs_data;
    endcase
    case (fwd_rt_sel)
      FWD_MEM: rt_f = fwd_mem_data;
      FWD_WB:  rt_f = fwd_wb_data;
      default: rt_f = in_rt_data;
    endcase
  end

  assign alu_a = rs_f;
  assign alu_b = in_src1_imm ? in_imm : rt_f;

  // ALU. Fixed shifts move operand B by shamt; variable shifts move rs by rt[4:0].
  always_comb begin
    alu_res = '0;
    case (in_alu_op)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_NOR:  alu_res = ~(alu_a | alu_b);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ALU_SLL:  alu_res = alu_b << in_shamt;
      ALU_SRL:  alu_res = alu_b >> in_shamt;
      ALU_SRA:  alu_res = $signed(alu_b) >>> in_shamt;
      ALU_SLLV: alu_res = alu_a << rt_f[4:0];
      ALU_SRLV: alu_res = alu_a >> rt_f[4:0];
      ALU_SRAV: alu_res = $signed(alu_a) >>> rt_f[4:0];
      default:  alu_res = '0;
    endcase
  end

  // Any instruction that touches HI/LO must wait for the unit to go idle.
  assign md_uses      = (in_md_op != MD_NONE) || (in_res_sel == RES_HI) || (in_res_sel == RES_LO);
  assign md_stall_req = in_valid & md_busy & md_uses;
  assign fire         = in_valid & ~md_stall_req & ~flush;
  assign md_start     = fire & md_is_start(in_md_op);
  assign wr_hi        = fire & (in_md_op == MD_MTHI);
  assign wr_lo        = fire & (in_md_op == MD_MTLO);

  md_unit #(
    .XLEN        (XLEN),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk     (clk),
    .reset   (reset),
    .start_i (md_start),
    .op_i    (in_md_op),
    .a_i     (rs_f),
    .b_i     (rt_f),
    .wr_hi_i (wr_hi),
    .wr_lo_i (wr_lo),
    .wdata_i (rs_f),
    .busy_o  (md_busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  // Result select; HI/LO reads see committed values only.
  always_comb begin
    case (in_res_sel)
      RES_HI:  result = hi;
      RES_LO:  result = lo;
      RES_PC8: result = in_pc + XLEN'(8);
      default: result = alu_res;
    endcase
  end

  assign bubble = flush | md_stall_req | ~in_valid;

  // EX/MEM register: a bubble on reset, flush, stall or an empty slot.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      out_valid    <= 1'b0;
      out_pc       <= RESET_PC;
      out_result   <= '0;
      out_dm_wdata <= '0;
      out_waddr    <= '0;
      out_tnew     <= '0;
    end else begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_result   <= result;
      out_dm_wdata <= rt_f;
      out_waddr    <= in_waddr;
      out_tnew     <= (in_tnew != 3'd0) ? in_tnew - 3'd1 : 3'd0;
    end
  end

endmodule
